// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, timeout default and dump sequencer state encoding
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam int BUSY_TO_DEF = 1023;
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_DATA,
        S_OFFER,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FINISH
    } dump_state_t;
endpackage

// File: rtl/dump_timeout_ctr.sv
// dump_timeout_ctr: loadable, clearable up-counter with terminal-count flag
module dump_timeout_ctr #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic         term
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (inc) cnt <= cnt + 1'b1;
    end
    assign term = (cnt == term_val);
endmodule

// File: rtl/uart_dump_ctrl.sv
// uart_dump_ctrl: streams a block of RAM bytes to the UART transmitter after a run
module uart_dump_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 16,
    parameter int RD_LAT  = 1,
    parameter int BUSY_TO = BUSY_TO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [BYTE_W-1:0] ram_rdata,
    output logic [BYTE_W-1:0] tx_tdata,
    output logic              tx_tvalid,
    input  logic              tx_busy,
    output logic              active,
    output logic              done,
    output logic [LEN_W-1:0]  sent_count,
    output logic              retry_err
);
    localparam int TW = $clog2(BUSY_TO + RD_LAT + 1);

    dump_state_t state, state_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0] remaining;
    logic [TW-1:0] ctr_term;
    logic ctr_clr, ctr_load, ctr_inc, ctr_hit;

    // one counter serves both the read-latency wait and the busy timeout
    assign ctr_term = (state == S_WAIT_DATA) ? TW'(RD_LAT) : TW'(BUSY_TO - 1);

    dump_timeout_ctr #(.W(TW)) u_ctr (
        .clk(clk),
        .rst(rst),
        .clr(ctr_clr),
        .load(ctr_load),
        .load_val(TW'(1)),
        .inc(ctr_inc),
        .term_val(ctr_term),
        .term(ctr_hit)
    );

    assign ram_addr = cur_addr;
    assign ram_rd = (state == S_READ);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ctr_clr = 1'b0;
        ctr_load = 1'b0;
        ctr_inc = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = (length == '0) ? S_FINISH : S_READ;
            S_READ: begin
                ctr_load = 1'b1;
                state_nx = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                ctr_inc = !ctr_hit;
                if (ctr_hit) state_nx = S_OFFER;
            end
            S_OFFER: begin
                ctr_clr = !tx_busy;
                if (!tx_busy) state_nx = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                ctr_inc = !tx_busy && !ctr_hit;
                state_nx = tx_busy ? S_WAIT_LO : ctr_hit ? S_OFFER : S_WAIT_HI;
            end
            S_WAIT_LO: if (!tx_busy) state_nx = (remaining == LEN_W'(1)) ? S_FINISH : S_READ;
            S_FINISH: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr <= '0;
            remaining <= '0;
            tx_tdata <= '0;
            tx_tvalid <= 1'b0;
            active <= 1'b0;
            done <= 1'b0;
            sent_count <= '0;
            retry_err <= 1'b0;
        end else begin
            tx_tvalid <= (state == S_OFFER) && !tx_busy;
            done <= (state == S_FINISH);
            if (state == S_IDLE && start) begin
                cur_addr <= base_addr;
                remaining <= length;
                sent_count <= '0;
                retry_err <= 1'b0;
                active <= 1'b1;
            end
            if (state == S_FINISH) active <= 1'b0;
            if (state == S_WAIT_DATA && ctr_hit) tx_tdata <= ram_rdata;
            if (state == S_WAIT_HI && !tx_busy && ctr_hit) retry_err <= 1'b1;
            if (state == S_WAIT_LO && !tx_busy) begin
                sent_count <= sent_count + 1'b1;
                cur_addr <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_dump_ctrl.sv
// tb_uart_dump_ctrl: directed vector bench with RAM and transmitter models
module tb_uart_dump_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic [15:0] base_addr = '0, length = '0, ram_addr, sent_count;
    logic ram_rd, tx_tvalid, tx_busy, active, done, retry_err;
    logic [7:0] ram_rdata = '0, tx_tdata;

    uart_dump_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rdata(ram_rdata),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_busy(tx_busy),
        .active(active), .done(done), .sent_count(sent_count), .retry_err(retry_err)
    );

    logic start_b = 1'b0;
    logic [3:0] base_b = '0, ram_addr_b;
    logic [7:0] len_b = '0, sent_b, rdata_b = '0, st_b = '0, tdata_b;
    logic ram_rd_b, tvalid_b, busy_b, active_b, done_b, retry_b;

    uart_dump_ctrl #(.ADDR_W(4), .LEN_W(8), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .length(len_b),
        .ram_addr(ram_addr_b), .ram_rd(ram_rd_b), .ram_rdata(rdata_b),
        .tx_tdata(tdata_b), .tx_tvalid(tvalid_b), .tx_busy(busy_b),
        .active(active_b), .done(done_b), .sent_count(sent_b), .retry_err(retry_b)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [16];
    int busy_len = 20, drop_at = -1, ntv = 0, bcnt = 0, bcnt_b = 0;

    always @(posedge clk) if (ram_rd) ram_rdata <= mem_a[ram_addr[7:0]];
    always @(posedge clk) begin
        st_b <= ram_rd_b ? mem_b[ram_addr_b] : 8'hEE;
        rdata_b <= st_b;
    end

    // transmitter models: independent of rst so an in-flight frame finishes
    always @(posedge clk) begin
        if (tx_tvalid) begin
            ntv <= ntv + 1;
            if (ntv != drop_at) bcnt <= busy_len;
        end else if (bcnt != 0) bcnt <= bcnt - 1;
        bcnt_b <= tvalid_b ? 8 : (bcnt_b != 0 ? bcnt_b - 1 : 0);
    end
    assign tx_busy = (bcnt != 0);
    assign busy_b = (bcnt_b != 0);

    logic [7:0] tv_q[$], tvb_q[$];
    logic [15:0] ad_q[$];
    logic [3:0] adb_q[$];
    int tvc_q[$];
    int cyc = 0, done_cnt = 0, doneb_cnt = 0, rcyc = -1;
    logic rprev = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_tvalid) begin
            tv_q.push_back(tx_tdata);
            tvc_q.push_back(cyc);
        end
        if (ram_rd) ad_q.push_back(ram_addr);
        if (done) done_cnt <= done_cnt + 1;
        if (retry_err && !rprev) rcyc <= cyc;
        rprev <= retry_err;
        if (tvalid_b) tvb_q.push_back(tdata_b);
        if (ram_rd_b) adb_q.push_back(ram_addr_b);
        if (done_b) doneb_cnt <= doneb_cnt + 1;
    end

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        int busy;
        bit drop;
        logic [15:0] sent;
        bit retry;
        int ntv;
    } vec_t;
    vec_t vt[5];
    logic [3:0] exp_ab[4] = '{4'hE, 4'hF, 4'h0, 4'h1};
    logic [7:0] exp_db[4] = '{8'h7E, 8'h7F, 8'h70, 8'h71};

    int total = 0, bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic kick(input logic [15:0] b, input logic [15:0] l);
        @(negedge clk);
        base_addr = b;
        length = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        int n;
        n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt != d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, a0, d0, j, n, reps;
        logic [7:0] e;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'(i) ^ 8'h5A;
        mem_a[8'h10] = 8'hA5; mem_a[8'h11] = 8'h3C; mem_a[8'h12] = 8'hFF; mem_a[8'h13] = 8'h00;
        for (int i = 0; i < 16; i++) mem_b[i] = {4'h7, 4'(i)};
        vt[0] = '{16'h0010, 16'd4, 640, 1'b0, 16'd4, 1'b0, 4};
        vt[1] = '{16'h0020, 16'd0, 20, 1'b0, 16'd0, 1'b0, 0};
        vt[2] = '{16'h0030, 16'd3, 20, 1'b1, 16'd3, 1'b1, 4};
        vt[3] = '{16'hFFFE, 16'd3, 20, 1'b0, 16'd3, 1'b0, 3};
        vt[4] = '{16'h0040, 16'd1, 1, 1'b0, 16'd1, 1'b0, 1};

        repeat (3) @(negedge clk);
        chk("rst_outs", {ram_addr, ram_rd, tx_tdata, tx_tvalid, active, done, sent_count, retry_err}, 0);
        chk("rst_b_active", active_b, 0);
        base_addr = 16'h0010; length = 16'd4; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_active", active, 0);
        chk("start_with_rst_rd", ram_rd, 0);

        for (int k = 0; k < 5; k++) begin
            t0 = tv_q.size(); a0 = ad_q.size(); d0 = done_cnt;
            busy_len = vt[k].busy;
            drop_at = vt[k].drop ? ntv : -1;
            kick(vt[k].base, vt[k].len);
            wait_done(d0, 8000);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_sent", k), sent_count, vt[k].sent);
            chk($sformatf("v%0d_retry", k), retry_err, vt[k].retry);
            chk($sformatf("v%0d_ntv", k), tv_q.size() - t0, vt[k].ntv);
            chk($sformatf("v%0d_nrd", k), ad_q.size() - a0, vt[k].len);
            chk($sformatf("v%0d_ndone", k), done_cnt - d0, 1);
            chk($sformatf("v%0d_active", k), active, 0);
            j = t0;
            for (int i = 0; i < int'(vt[k].len); i++) begin
                chk($sformatf("v%0d_addr%0d", k, i), ad_q[a0 + i], 16'(vt[k].base + 16'(i)));
                e = mem_a[8'(vt[k].base + 16'(i))];
                reps = (vt[k].drop && i == 0) ? 2 : 1;
                for (int r = 0; r < reps; r++) begin
                    chk($sformatf("v%0d_byte%0d", k, j - t0), tv_q[j], e);
                    j++;
                end
            end
            if (vt[k].drop) begin
                chk("retry_latency", rcyc - tvc_q[t0], 1023);
                chk("reoffer_gap", tvc_q[t0 + 1] - tvc_q[t0], 1024);
            end
        end

        @(negedge clk);
        base_addr = 16'h0020; length = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zl_active_c1", active, 1);
        chk("zl_done_c1", done, 0);
        @(negedge clk);
        chk("zl_done_c2", done, 1);
        chk("zl_active_c2", active, 0);
        @(negedge clk);
        chk("zl_done_c3", done, 0);

        busy_len = 40; drop_at = -1;
        t0 = tv_q.size(); a0 = ad_q.size(); d0 = done_cnt;
        kick(16'h0010, 16'd3);
        n = 0;
        while (tv_q.size() - t0 < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        kick(16'h0050, 16'd1);
        chk("swa_active", active, 1);
        wait_done(d0, 2000);
        repeat (3) @(negedge clk);
        chk("swa_sent", sent_count, 3);
        chk("swa_ntv", tv_q.size() - t0, 3);
        chk("swa_addr2", ad_q[a0 + 2], 16'h0012);
        chk("swa_byte2", tv_q[t0 + 2], 8'hFF);
        chk("swa_ndone", done_cnt - d0, 1);

        a0 = ad_q.size(); d0 = done_cnt;
        kick(16'h0010, 16'd4);
        n = 0;
        while (!tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_active", active, 0);
        chk("rm_tvalid", tx_tvalid, 0);
        chk("rm_sent", sent_count, 0);
        repeat (100) @(negedge clk);
        chk("rm_no_done", done_cnt - d0, 0);
        chk("rm_reads", ad_q.size() - a0, 1);

        @(negedge clk);
        base_b = 4'hE; len_b = 8'd4; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (doneb_cnt == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("b_ndone", doneb_cnt, 1);
        chk("b_sent", sent_b, 4);
        chk("b_ntv", tvb_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_addr%0d", i), adb_q[i], exp_ab[i]);
            chk($sformatf("b_byte%0d", i), tvb_q[i], exp_db[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
